// File: rtl/ad5318_spi_ctrl_if.sv
// Command stream into the AD5318 serialiser.
// One 16-bit word plus channel address per valid/ready handshake.
interface ad5318_spi_ctrl_if;
  logic [15:0] tdata;
  logic [2:0]  tuser;
  logic        tvalid;
  logic        tready;

  modport master (
    output tdata, tuser, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tuser, tvalid,
    output tready
  );
endinterface

// File: rtl/ad5318_spi_ctrl.sv
// AD5318 octal DAC 3-wire serialiser with optional LDAC pulse.
// Frames one 16-bit word MSB-first, sampled by the DAC on SCLK falls.
module ad5318_spi_ctrl #(
  parameter int CLK_DIV    = 2,
  parameter int SYNC_GAP   = 4,
  parameter int LDAC_PULSE = 0
) (
  input  logic clkin,
  input  logic rstn,
  ad5318_spi_ctrl_if.slave s,
  output logic SCLK,
  output logic DIN,
  output logic SYNC_b,
  output logic LDAC_b
);

  typedef enum logic [2:0] {
    IDLE, SHIFT, HOLD, GAP, LDAC
  } state_e;

  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_M1  = 16'(SYNC_GAP - 1);
  localparam logic [15:0] LDAC_M1 = 16'(2 * CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] word_q, word_d;
  logic        data_q, data_d;
  logic        sclk_q, sclk_d;
  logic        din_q, din_d;
  logic        sync_q, sync_d;
  logic        ldac_q, ldac_d;
  logic        rdy_q, rdy_d;

  logic        half_done;
  logic [3:0]  nxt_bit;
  logic        unused_bits;

  assign unused_bits = ^s.tdata[14:10];
  assign half_done   = (cnt_q == HALF_M1);
  assign nxt_bit     = bit_q - 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    word_d  = word_q;
    data_d  = data_q;
    sclk_d  = sclk_q;
    din_d   = din_q;
    sync_d  = sync_q;
    ldac_d  = ldac_q;
    rdy_d   = rdy_q;
    unique case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (s.tvalid && rdy_q) begin
          rdy_d   = 1'b0;
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = 4'd15;
          data_d  = ~s.tdata[15];
          word_d  = s.tdata[15] ? s.tdata
                  : {1'b0, s.tuser, s.tdata[9:0], 2'b00};
          sync_d  = 1'b0;
          sclk_d  = 1'b1;
          din_d   = s.tdata[15];
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + 16'd1;
        if (half_done) begin
          cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_q == 4'd0) state_d = HOLD;
          end else begin
            sclk_d = 1'b1;
            bit_d  = nxt_bit;
            din_d  = word_q[nxt_bit];
          end
        end
      end
      // last low phase: SCLK and SYNC_b rise together
      HOLD: begin
        cnt_d = cnt_q + 16'd1;
        if (half_done) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          sync_d  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == GAP_M1) begin
          cnt_d = '0;
          if (LDAC_PULSE != 0 && data_q) begin
            state_d = LDAC;
            ldac_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      LDAC: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == LDAC_M1) begin
          cnt_d   = '0;
          ldac_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      data_q  <= 1'b0;
      sclk_q  <= 1'b1;
      din_q   <= 1'b0;
      sync_q  <= 1'b1;
      ldac_q  <= 1'b1;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      data_q  <= data_d;
      sclk_q  <= sclk_d;
      din_q   <= din_d;
      sync_q  <= sync_d;
      ldac_q  <= ldac_d;
      rdy_q   <= rdy_d;
    end
  end

  assign s.tready = rdy_q;
  assign SCLK     = sclk_q;
  assign DIN      = din_q;
  assign SYNC_b   = sync_q;
  assign LDAC_b   = ldac_q;

endmodule

// File: tb/tb_ad5318_spi_ctrl.sv
// Directed bench for ad5318_spi_ctrl with a DAC-side shift model.
// Checks framing, word formation, LDAC pulse and mid-frame abort.
module tb_ad5318_spi_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic SCLK, DIN, SYNC_b, LDAC_b;

  ad5318_spi_ctrl_if bus ();

  ad5318_spi_ctrl #(
    .CLK_DIV(2), .SYNC_GAP(4), .LDAC_PULSE(1)
  ) dut (
    .clkin(clk), .rstn(rstn), .s(bus.slave),
    .SCLK(SCLK), .DIN(DIN), .SYNC_b(SYNC_b), .LDAC_b(LDAC_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int accepts = 0;
  int sync_low = 0;
  int ldac_low = 0;
  int fall_cnt = 0;
  int fall_base = 0;
  int edge_hi = 0;
  int din_bad = 0;
  logic [15:0] dac_sr = '0;
  logic sclk_p = 1'b1;
  logic din_p = 1'b0;

  // cycle counters restart at each accepted command
  always @(posedge clk) begin
    if (!SYNC_b) sync_low++;
    if (!LDAC_b) ldac_low++;
    if (bus.tvalid && bus.tready && !rstn) begin
      acc_cyc = cyc;
      accepts++;
      sync_low = 0;
      ldac_low = 0;
      fall_base = fall_cnt;
    end
    cyc++;
  end

  always @(negedge SCLK) begin
    if (!SYNC_b) begin
      dac_sr = {dac_sr[14:0], DIN};
      fall_cnt++;
    end else begin
      edge_hi++;
    end
  end

  always @(negedge clk) begin
    if (!SCLK && !sclk_p && DIN !== din_p) din_bad++;
    sclk_p = SCLK;
    din_p = DIN;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.tready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  int lat;

  task automatic run_frame(input logic [15:0] d,
                           input logic [2:0] u,
                           input logic [15:0] exp,
                           input int exp_ldac,
                           input string tag);
    int acc0;
    @(negedge clk);
    wait_ready({tag, "_pre"});
    acc0 = accepts;
    bus.tdata = d;
    bus.tuser = u;
    bus.tvalid = 1'b1;
    repeat (8) @(negedge clk);
    bus.tvalid = 1'b0;
    wait_ready(tag);
    lat = cyc - acc_cyc - 1;
    chk({tag, "_word"}, 32'(dac_sr), 32'(exp));
    chk({tag, "_falls"}, 32'(fall_cnt - fall_base), 32'd16);
    chk({tag, "_synclow"}, 32'(sync_low), 32'd64);
    chk({tag, "_ldaclow"}, 32'(ldac_low), 32'(exp_ldac));
    chk({tag, "_accepts"}, 32'(accepts - acc0), 32'd1);
  endtask

  initial begin
    int n;
    bus.tdata = '0;
    bus.tuser = '0;
    bus.tvalid = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_sclk", 32'(SCLK), 32'd1);
    chk("rst_sync", 32'(SYNC_b), 32'd1);
    chk("rst_ldac", 32'(LDAC_b), 32'd1);
    chk("rst_tready", 32'(bus.tready), 32'd0);
    chk("rst_din", 32'(DIN), 32'd0);
    rstn = 1'b0;
    @(negedge clk);
    chk("rel_tready", 32'(bus.tready), 32'd1);

    run_frame(16'h8030, 3'b000, 16'h8030, 0, "ref");
    chk("ref_latency", 32'(lat), 32'd69);
    run_frame(16'hC000, 3'b101, 16'hC000, 0, "pwr_on");
    run_frame(16'h0001, 3'b100, 16'h4004, 4, "chan_e");
    run_frame(16'hA002, 3'b011, 16'hA002, 0, "ldac_mode");
    run_frame(16'h7FFF, 3'b000, 16'h0FFC, 4, "ign_bits");

    // abort after the 5th falling edge
    @(negedge clk);
    wait_ready("abort_pre");
    bus.tdata = 16'h03FF;
    bus.tuser = 3'b010;
    bus.tvalid = 1'b1;
    @(negedge clk);
    bus.tvalid = 1'b0;
    n = 0;
    while ((fall_cnt - fall_base) < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("abort_timeout", 32'd0, 32'd1);
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_sync", 32'(SYNC_b), 32'd1);
    chk("abort_sclk", 32'(SCLK), 32'd1);
    chk("abort_tready", 32'(bus.tready), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_falls", 32'(fall_cnt - fall_base), 32'd5);
    rstn = 1'b0;
    run_frame(16'h0155, 3'b111, 16'h7554, 4, "post_abort");

    chk("edges_sync_high", 32'(edge_hi), 32'd0);
    chk("din_stable_low", 32'(din_bad), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
